// File: rtl/blok_wyjsc_buforowany_pkg.sv
// Shared definitions for the output-image bank and the CPU-side bus model.
// Pure types and functions; no timing of its own.
// No flow control: everything here is combinational.
package blok_wyjsc_pkg;

   // CPU write modes applied to the selected shadow channel
   typedef enum logic [1:0] {
      TRYB_LOAD = 2'b00,
      TRYB_SET  = 2'b01,
      TRYB_CLR  = 2'b10,
      TRYB_TGL  = 2'b11
   } tryb_e;

   // Write-data rule f(tryb, old, in). Every mode is bitwise, so the rule is
   // stated per bit and callers loop over any channel width.
   function automatic logic f_zapis_bit(tryb_e tryb, logic old_b, logic in_b);
      logic res;
      res = in_b;
      case (tryb)
         TRYB_LOAD: res = in_b;
         TRYB_SET:  res = old_b | in_b;
         TRYB_CLR:  res = old_b & ~in_b;
         TRYB_TGL:  res = old_b ^ in_b;
         default:   res = in_b;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/blok_wyjsc_buforowany_if.sv
// CPU I/O bus into the output-image bank: write port, commit/clear strobes, readback.
// Readback data returns one clock after rd_sel is presented.
// No backpressure: the bank accepts one write and one commit every clock.
interface blok_wyjsc_buforowany_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 8
);
   import blok_wyjsc_pkg::*;

   localparam int SEL_W = $clog2(NUM_CH);

   logic [WIDTH-1:0] in;
   logic [SEL_W-1:0] sel;
   tryb_e            tryb;
   logic             zapis;
   logic             zatwierdz;
   logic             kasuj_blad;
   logic [SEL_W-1:0] rd_sel;
   logic [WIDTH-1:0] rd_data;

   modport master (
      output in, sel, tryb, zapis, zatwierdz, kasuj_blad, rd_sel,
      input  rd_data
   );

   modport slave (
      input  in, sel, tryb, zapis, zatwierdz, kasuj_blad, rd_sel,
      output rd_data
   );

endinterface

// File: rtl/blok_wyjsc_buforowany_licznik_watchdog.sv
// Scan watchdog: counts clocks since the last kick and pulses expire when the budget runs out.
// expire is combinational from the count; it fires on the edge that would exceed WDT_CYCLES-1.
// No backpressure; a kick or clear on the expiring edge suppresses the pulse.
module licznik_watchdog #(
   parameter int WDT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic kick,
   input  logic clear,
   output logic expire
);

   localparam int               CNT_W   = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   localparam bit               ENABLED = (WDT_CYCLES > 0);
   localparam logic [CNT_W-1:0] CNT_MAX = (WDT_CYCLES > 0) ? CNT_W'(WDT_CYCLES - 1) : '0;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: restart on kick/clear, otherwise climb and park at CNT_MAX
   always_comb begin
      cnt_d = cnt_q;
      if (!ENABLED || kick || clear) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Expiry: budget exhausted and nothing on this edge restarts the count
   always_comb begin
      expire = ENABLED && (cnt_q == CNT_MAX) && !kick && !clear;
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/blok_wyjsc_buforowany.sv
// PLC output-image bank: CPU writes a shadow image, a commit copies it atomically to the pins.
// Commit visible 1 clock after the strobe; readback 1 clock after rd_sel; fault forces SAFE_VALUE.
// No backpressure: writes/commits are accepted every clock; out-of-range writes are dropped.
module blok_wyjsc_buforowany
   import blok_wyjsc_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter int               NUM_CH     = 8,
   parameter int               WDT_CYCLES = 1000000,
   parameter logic [WIDTH-1:0] SAFE_VALUE = {WIDTH{1'b0}}
) (
   input  logic                      clk,
   input  logic                      rst_n,
   blok_wyjsc_buforowany_if.slave    bus,
   output logic [NUM_CH*WIDTH-1:0]   out_flat,
   output logic                      blad
);

   localparam int SEL_W = $clog2(NUM_CH);

   logic [WIDTH-1:0] shadow_q [NUM_CH];
   logic [WIDTH-1:0] shadow_d [NUM_CH];
   logic [WIDTH-1:0] out_q    [NUM_CH];
   logic [WIDTH-1:0] out_d    [NUM_CH];
   logic [WIDTH-1:0] rd_data_q;
   logic [WIDTH-1:0] rd_data_d;
   logic             blad_q;
   logic             blad_d;

   logic [SEL_W-1:0] wr_sel;
   logic [SEL_W-1:0] rd_sel;
   logic             wr_ok;
   logic             rd_ok;
   logic             commit_ok;
   logic             wdt_expire;

   assign wr_sel = bus.sel;
   assign rd_sel = bus.rd_sel;

   // Channel-range qualifiers (matter only when NUM_CH is not a power of two)
   always_comb begin
      wr_ok = bus.zapis && (32'(wr_sel) < NUM_CH);
      rd_ok = (32'(rd_sel) < NUM_CH);
   end

   // A commit is refused while faulted unless the fault is cleared on the same edge
   always_comb begin
      commit_ok = bus.zatwierdz && (!blad_q || bus.kasuj_blad);
   end

   licznik_watchdog #(
      .WDT_CYCLES (WDT_CYCLES)
   ) u_licznik_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .kick   (commit_ok),
      .clear  (bus.kasuj_blad),
      .expire (wdt_expire)
   );

   // Shadow image update: one read-modify-write on the selected channel
   always_comb begin
      shadow_d = shadow_q;
      if (wr_ok) begin
         for (int b = 0; b < WIDTH; b++) begin
            shadow_d[wr_sel][b] = f_zapis_bit(bus.tryb, shadow_q[wr_sel][b], bus.in[b]);
         end
      end
   end

   // Output image: commit takes the post-write shadow; expiry forces the safe pattern
   always_comb begin
      out_d = out_q;
      if (commit_ok) begin
         out_d = shadow_d;
      end else if (wdt_expire) begin
         for (int k = 0; k < NUM_CH; k++) begin
            out_d[k] = SAFE_VALUE;
         end
      end
   end

   // Fault flag: clear has priority, otherwise sticky once the watchdog expires
   always_comb begin
      blad_d = blad_q;
      if (bus.kasuj_blad) begin
         blad_d = 1'b0;
      end else if (wdt_expire) begin
         blad_d = 1'b1;
      end
   end

   // Readback shows the shadow as it stood before this edge's write
   always_comb begin
      rd_data_d = '0;
      if (rd_ok) begin
         rd_data_d = shadow_q[rd_sel];
      end
   end

   // State registers; reset drives the pins to the safe pattern immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            shadow_q[k] <= '0;
            out_q[k]    <= SAFE_VALUE;
         end
         rd_data_q <= '0;
         blad_q    <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         out_q     <= out_d;
         rd_data_q <= rd_data_d;
         blad_q    <= blad_d;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_out_flat
      assign out_flat[k*WIDTH +: WIDTH] = out_q[k];
   end

   assign bus.rd_data = rd_data_q;
   assign blad        = blad_q;

endmodule

// File: tb/tb_blok_wyjsc_buforowany.sv
// Bench for the output-image bank: two instances (8 ch with 16-cycle watchdog, 6 ch without).
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Directed stimulus plus literal expectations for the key scenarios.
module tb_blok_wyjsc_buforowany;
   import blok_wyjsc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] w_in = '0;
   logic [2:0] w_sel = '0;
   tryb_e      w_tryb = TRYB_LOAD;
   logic       w_zapis = 1'b0;
   logic       w_zat = 1'b0;
   logic       w_kas = 1'b0;
   logic [2:0] w_rd_sel = '0;

   logic [63:0] out_a;
   logic [47:0] out_b;
   logic        blad_a;
   logic        blad_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   blok_wyjsc_buforowany_if #(.WIDTH(8), .NUM_CH(8)) bus_a ();
   blok_wyjsc_buforowany_if #(.WIDTH(8), .NUM_CH(6)) bus_b ();

   assign bus_a.in = w_in;          assign bus_b.in = w_in;
   assign bus_a.sel = w_sel;        assign bus_b.sel = w_sel;
   assign bus_a.tryb = w_tryb;      assign bus_b.tryb = w_tryb;
   assign bus_a.zapis = w_zapis;    assign bus_b.zapis = w_zapis;
   assign bus_a.zatwierdz = w_zat;  assign bus_b.zatwierdz = w_zat;
   assign bus_a.kasuj_blad = w_kas; assign bus_b.kasuj_blad = w_kas;
   assign bus_a.rd_sel = w_rd_sel;  assign bus_b.rd_sel = w_rd_sel;

   blok_wyjsc_buforowany #(
      .WIDTH(8), .NUM_CH(8), .WDT_CYCLES(16), .SAFE_VALUE(8'h3C)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .out_flat(out_a), .blad(blad_a)
   );

   blok_wyjsc_buforowany #(
      .WIDTH(8), .NUM_CH(6), .WDT_CYCLES(0), .SAFE_VALUE(8'h00)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .out_flat(out_b), .blad(blad_b)
   );

   // ---------------- behavioural model ----------------
   function automatic int nch_of(int d);   return (d == 0) ? 8 : 6;   endfunction
   function automatic int wdt_of(int d);   return (d == 0) ? 16 : 0;  endfunction
   function automatic logic [7:0] safe_of(int d); return (d == 0) ? 8'h3C : 8'h00; endfunction

   logic [7:0] m_sh  [2][8];
   logic [7:0] m_out [2][8];
   logic [7:0] m_rd  [2];
   bit         m_fault [2];
   int         m_idle  [2];   // edges since the last accepted commit / clear / reset

   task automatic model_reset(int d);
      for (int k = 0; k < 8; k++) begin
         m_sh[d][k]  = 8'h00;
         m_out[d][k] = safe_of(d);
      end
      m_rd[d] = 8'h00;
      m_fault[d] = 0;
      m_idle[d] = 0;
   endtask

   task automatic model_edge(int d);
      logic [7:0] nsh [8];
      bit acc;
      for (int k = 0; k < 8; k++) nsh[k] = m_sh[d][k];
      if (w_zapis && int'(w_sel) < nch_of(d)) begin
         case (w_tryb)
            TRYB_LOAD: nsh[w_sel] = w_in;
            TRYB_SET:  nsh[w_sel] = m_sh[d][w_sel] | w_in;
            TRYB_CLR:  nsh[w_sel] = m_sh[d][w_sel] & ~w_in;
            default:   nsh[w_sel] = m_sh[d][w_sel] ^ w_in;
         endcase
      end
      m_rd[d] = (int'(w_rd_sel) < nch_of(d)) ? m_sh[d][w_rd_sel] : 8'h00;
      acc = w_zat && (!m_fault[d] || w_kas);
      if (w_kas) begin
         m_fault[d] = 0;
         m_idle[d] = 0;
      end
      if (acc) begin
         for (int k = 0; k < 8; k++) m_out[d][k] = nsh[k];
         m_idle[d] = 0;
      end else if (!w_kas) begin
         m_idle[d]++;
         if (wdt_of(d) > 0 && m_idle[d] >= wdt_of(d) && !m_fault[d]) begin
            m_fault[d] = 1;
            for (int k = 0; k < 8; k++) m_out[d][k] = safe_of(d);
         end
      end
      for (int k = 0; k < 8; k++) m_sh[d][k] = nsh[k];
   endtask

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) model_reset(d);
         else        model_edge(d);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_flat(int d);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < nch_of(d); k++) v[k*8 +: 8] = m_out[d][k];
      return v;
   endfunction

   always @(negedge clk) begin
      chk("cyc_out_a",  out_a, model_flat(0));
      chk("cyc_blad_a", {63'b0, blad_a}, {63'b0, m_fault[0]});
      chk("cyc_rd_a",   {56'b0, bus_a.rd_data}, {56'b0, m_rd[0]});
      chk("cyc_out_b",  {16'b0, out_b}, model_flat(1));
      chk("cyc_blad_b", {63'b0, blad_b}, {63'b0, m_fault[1]});
      chk("cyc_rd_b",   {56'b0, bus_b.rd_data}, {56'b0, m_rd[1]});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] SAFE_A = {8{8'h3C}};

   // ---------------- directed stimulus ----------------
   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rst_out_a", out_a, SAFE_A);
      chk("rst_out_b", {16'b0, out_b}, 64'h0);
      chk("rst_blad_a", {63'b0, blad_a}, 64'h0);
      chk("rst_rd_a", {56'b0, bus_a.rd_data}, 64'h0);

      // write modes on channel 3
      w_rd_sel = 3'd3; w_sel = 3'd3; w_zapis = 1'b1;
      w_tryb = TRYB_LOAD; w_in = 8'hA5; tick();
      w_tryb = TRYB_SET;  w_in = 8'h0F; tick();
      chk("mode_load", {56'b0, bus_a.rd_data}, 64'hA5);
      w_tryb = TRYB_CLR;  w_in = 8'h81; tick();
      chk("mode_set", {56'b0, bus_a.rd_data}, 64'hAF);
      w_tryb = TRYB_TGL;  w_in = 8'hFF; tick();
      chk("mode_clr", {56'b0, bus_a.rd_data}, 64'h2E);
      w_zapis = 1'b0; tick();
      chk("mode_tgl", {56'b0, bus_a.rd_data}, 64'hD1);
      chk("precommit_a", out_a, SAFE_A);
      chk("precommit_b", {16'b0, out_b}, 64'h0);
      w_zat = 1'b1; tick(); w_zat = 1'b0;
      chk("commit_a", out_a, 64'h00000000_D1000000);
      chk("commit_b", {16'b0, out_b}, 64'h0000_0000_D1000000);

      // atomic commit together with a same-edge write
      w_zapis = 1'b1; w_tryb = TRYB_LOAD; w_sel = 3'd0; w_in = 8'h11; tick();
      chk("atomic_pre_a", out_a, 64'h00000000_D1000000);
      w_sel = 3'd7; w_in = 8'h77; w_zat = 1'b1; tick();
      w_zapis = 1'b0; w_zat = 1'b0;
      chk("atomic_a", out_a, 64'h77000000_D1000011);
      chk("atomic_b", {16'b0, out_b}, 64'h0000_0000_D1000011);

      // out-of-range channels on the 6-channel instance
      w_rd_sel = 3'd7; w_zapis = 1'b1; w_sel = 3'd6; w_in = 8'hFF; tick();
      w_sel = 3'd7; w_zat = 1'b1; tick();
      w_zapis = 1'b0; w_zat = 1'b0;
      chk("oor_rd_b", {56'b0, bus_b.rd_data}, 64'h0);
      chk("oor_rd_a_prewrite", {56'b0, bus_a.rd_data}, 64'h77);
      chk("oor_out_a", out_a, 64'hFFFF0000_D1000011);
      chk("oor_out_b", {16'b0, out_b}, 64'h0000_0000_D1000011);
      tick();
      chk("oor_rd_a_post", {56'b0, bus_a.rd_data}, 64'hFF);

      // watchdog expiry after 16 edges without commit
      repeat (14) tick();
      chk("wdt_not_yet", {63'b0, blad_a}, 64'h0);
      tick();
      chk("wdt_blad", {63'b0, blad_a}, 64'h1);
      chk("wdt_safe_a", out_a, SAFE_A);
      chk("wdt_off_b", {63'b0, blad_b}, 64'h0);
      w_zat = 1'b1; tick(); w_zat = 1'b0;
      chk("wdt_commit_ignored", out_a, SAFE_A);
      w_kas = 1'b1; tick(); w_kas = 1'b0;
      chk("wdt_cleared", {63'b0, blad_a}, 64'h0);
      chk("wdt_still_safe", out_a, SAFE_A);
      w_zat = 1'b1; tick(); w_zat = 1'b0;
      chk("wdt_restored", out_a, 64'hFFFF0000_D1000011);
      repeat (15) tick();
      w_zat = 1'b1; tick(); w_zat = 1'b0;
      chk("wdt_commit_at_16", {63'b0, blad_a}, 64'h0);
      chk("wdt_commit_at_16_out", out_a, 64'hFFFF0000_D1000011);

      // clear and commit on the same edge while faulted
      w_zapis = 1'b1; w_tryb = TRYB_TGL; w_sel = 3'd1; w_in = 8'h0F; tick();
      w_zapis = 1'b0;
      repeat (15) tick();
      chk("fault2", {63'b0, blad_a}, 64'h1);
      w_kas = 1'b1; w_zat = 1'b1; tick(); w_kas = 1'b0; w_zat = 1'b0;
      chk("kas_zat_blad", {63'b0, blad_a}, 64'h0);
      chk("kas_zat_out_a", out_a, 64'hFFFF0000_D1000F11);
      chk("kas_zat_out_b", {16'b0, out_b}, 64'h0000_0000_D1000F11);

      // asynchronous reset in the middle of a cycle
      w_zapis = 1'b1; w_tryb = TRYB_LOAD; w_sel = 3'd2; w_in = 8'h22; tick();
      w_zapis = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_a", out_a, SAFE_A);
      chk("async_out_b", {16'b0, out_b}, 64'h0);
      chk("async_blad_a", {63'b0, blad_a}, 64'h0);
      chk("async_rd_a", {56'b0, bus_a.rd_data}, 64'h0);
      tick();
      rst_n = 1'b1; w_rd_sel = 3'd3; tick();
      chk("post_rst_rd", {56'b0, bus_a.rd_data}, 64'h0);
      w_zat = 1'b1; tick(); w_zat = 1'b0;
      chk("post_rst_commit", out_a, 64'h0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
